// File: rtl/fifo_wr_ctrl_pkg.sv
// rtl/fifo_wr_ctrl_pkg.sv - shared constants and Gray-code helpers for the FIFO pointer logic
package fifo_wr_ctrl_pkg;

  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_AF_THRESH   = 12;
  localparam int DEF_SYNC_STAGES = 2;

  // Helpers work on 32-bit values; callers zero-extend in and truncate out,
  // which keeps the conversions exact for any pointer width up to 32.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i + 1] ^ g[i];
    end
    return b;
  endfunction

  // Gray value the write pointer reaches when it is exactly one depth ahead
  // of the read pointer: the top two bits of a pw-bit Gray word inverted.
  function automatic logic [31:0] full_target(input logic [31:0] rq, input int pw);
    return rq ^ (32'h3 << (pw - 2));
  endfunction

endpackage

// File: rtl/gray_ctr.sv
// rtl/gray_ctr.sv - Gray-coded counter with registered output and next-value lookahead
module gray_ctr
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_next
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next;

  // Next binary count and its Gray image, exported for look-ahead compares.
  always_comb begin
    bin_next  = bin + WIDTH'(inc);
    gray_next = WIDTH'(bin2gray(32'(bin_next)));
  end

  // Count register; the Gray copy is registered so it is glitch-free across domains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/ptr_sync.sv
// rtl/ptr_sync.sv - N-stage flop synchronizer for a Gray-coded pointer
module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  // Plain shift chain; the first stage samples the foreign pointer directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i - 1];
      end
    end
  end

  assign q = stg[STAGES - 1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-side pointer, full/almost_full and level for the dual-clock sample FIFO
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int AF_THRESH   = DEF_AF_THRESH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level
);

  localparam int PTR_W = ADDR_W + 1;

  logic             accept;
  logic [PTR_W-1:0] bin;
  logic [PTR_W-1:0] bin_next;
  logic [PTR_W-1:0] gray_next;
  logic [PTR_W-1:0] rq_gray;
  logic [PTR_W-1:0] rq_bin;
  logic [PTR_W-1:0] fill_next;
  logic             full_next;

  // Handshake: ready follows the registered full and is forced low during reset,
  // which also drops any write presented while reset is active.
  always_comb begin
    wr_ready  = ~full & ~rst;
    accept    = wr_valid & wr_ready;
    wr_en     = accept;
    wr_addr   = bin[ADDR_W-1:0];
    bin_next  = bin + PTR_W'(accept);
    rq_bin    = PTR_W'(gray2bin(32'(rq_gray)));
    fill_next = bin_next - rq_bin;
    full_next = (gray_next == PTR_W'(full_target(32'(rq_gray), PTR_W)));
  end

  gray_ctr #(
    .WIDTH (PTR_W)
  ) u_gray_ctr (
    .clk       (clk),
    .rst_n     (~rst),
    .inc       (accept),
    .gray      (wr_ptr_gray),
    .gray_next (gray_next)
  );

  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk (clk),
    .rst (rst),
    .d   (rd_ptr_gray),
    .q   (rq_gray)
  );

  // Binary pointer and flags update together so a write and its flags land on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin         <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      level       <= '0;
    end else begin
      bin         <= bin_next;
      full        <= full_next;
      almost_full <= (fill_next >= PTR_W'(AF_THRESH));
      level       <= fill_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - directed table-driven bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] level;

  int total_cnt;
  int pass_cnt;

  typedef struct {
    logic       wr_valid;
    logic [4:0] rd_gray;
    logic       exp_wr_en;
    logic [3:0] exp_addr;
    logic       exp_full;
    logic       exp_af;
    logic [4:0] exp_level;
  } vec_t;

  vec_t vecs[$];

  fifo_wr_ctrl #(
    .ADDR_W      (4),
    .AF_THRESH   (12),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .level       (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic v, input logic [4:0] rg, input logic en, input logic [3:0] a,
                     input logic f, input logic af, input logic [4:0] lv);
    vec_t x;
    x.wr_valid = v; x.rd_gray = rg; x.exp_wr_en = en; x.exp_addr = a;
    x.exp_full = f; x.exp_af = af; x.exp_level = lv;
    vecs.push_back(x);
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i < last; i++) begin
      wr_valid    = vecs[i].wr_valid;
      rd_ptr_gray = vecs[i].rd_gray;
      #1;
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vecs[i].exp_wr_en));
      if (vecs[i].exp_wr_en) chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].exp_full));
      chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].exp_af));
      chk($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].exp_level));
      chk($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(!vecs[i].exp_full));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; wr_valid = 1'b0; rd_ptr_gray = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int a_end;
    int wcount;
    int rcount;
    total_cnt = 0; pass_cnt = 0;
    rst = 1'b1; wr_valid = 1'b0; rd_ptr_gray = '0;

    // Fill from empty with reads stalled, then overrun attempts while full.
    for (int i = 0; i < 20; i++)
      add(1'b1, 5'd0, i < 16, (i < 16) ? 4'(i) : 4'd0, i >= 15, (i + 1) >= 12,
          (i < 16) ? 5'(i + 1) : 5'd16);
    // One read: full clears on the third edge, then one write to address 0 refills.
    add(1'b1, 5'd1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd16);
    add(1'b1, 5'd1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd16);
    add(1'b1, 5'd1, 1'b0, 4'd0, 1'b0, 1'b1, 5'd15);
    add(1'b1, 5'd1, 1'b1, 4'd0, 1'b1, 1'b1, 5'd16);
    a_end = vecs.size();
    // Almost-full boundary: 11 words, 12th asserts, one read clears three edges later.
    for (int i = 0; i < 12; i++)
      add(1'b1, 5'd0, 1'b1, 4'(i), 1'b0, (i + 1) >= 12, 5'(i + 1));
    add(1'b0, 5'd1, 1'b0, 4'd0, 1'b0, 1'b1, 5'd12);
    add(1'b0, 5'd1, 1'b0, 4'd0, 1'b0, 1'b1, 5'd12);
    add(1'b0, 5'd1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd11);

    #1;
    chk("reset wr_ready", 32'(wr_ready), 32'd0);
    chk("reset full", 32'(full), 32'd0);
    chk("reset level", 32'(level), 32'd0);
    chk("reset wr_ptr_gray", 32'(wr_ptr_gray), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    run_vecs(0, a_end);

    // Asynchronous reset from the full state, no clock edge in between.
    @(negedge clk);
    #1;
    wr_valid = 1'b1;
    rst = 1'b1;
    rd_ptr_gray = '0;
    #1;
    chk("async rst wr_ready", 32'(wr_ready), 32'd0);
    chk("async rst wr_en", 32'(wr_en), 32'd0);
    chk("async rst full", 32'(full), 32'd0);
    chk("async rst almost_full", 32'(almost_full), 32'd0);
    chk("async rst level", 32'(level), 32'd0);
    chk("async rst wr_ptr_gray", 32'(wr_ptr_gray), 32'd0);
    chk("async rst wr_addr", 32'(wr_addr), 32'd0);
    @(negedge clk);
    wr_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post rst wr_ready", 32'(wr_ready), 32'd1);
    chk("post rst level", 32'(level), 32'd0);

    run_vecs(a_end, vecs.size());

    // Wrap: 100 words with the read pointer trailing by five words.
    do_reset();
    wcount = 0;
    while (wcount < 100) begin
      rd_ptr_gray = (wcount >= 5) ? g(5'(wcount - 5)) : 5'd0;
      wr_valid = 1'b1;
      #1;
      chk("wrap wr_en", 32'(wr_en), 32'd1);
      chk("wrap wr_addr", 32'(wr_addr), 32'(wcount % 16));
      chk("wrap wr_ptr_gray", 32'(wr_ptr_gray), 32'(g(5'(wcount))));
      @(posedge clk);
      #1;
      wcount++;
      chk("wrap full", 32'(full), 32'd0);
      if (wcount >= 10) chk("wrap level", 32'(level), 32'd8);
    end
    chk("wrap final gray", 32'(wr_ptr_gray), 32'(g(5'd100)));

    // Random producer against slow reads: no write while full, no address gaps.
    do_reset();
    wcount = 0;
    rcount = 0;
    for (int c = 0; c < 400; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0 && rcount < wcount) rcount++;
      rd_ptr_gray = g(5'(rcount));
      #1;
      if (full) chk("rand no write while full", 32'(wr_en), 32'd0);
      if (wr_en) begin
        chk("rand wr_addr", 32'(wr_addr), 32'(wcount % 16));
        wcount++;
      end
      @(posedge clk);
      #1;
      chk("rand occupancy bound", 32'((wcount - rcount) <= 16), 32'd1);
    end
    chk("rand made progress", 32'(wcount > 16), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the dual-clock sample FIFO in the stream path. It owns the write pointer, which is a Gray-coded counter, and drives the RAM write port. It also synchronizes the read-domain Gray pointer and generates full, almost_full and fill level, so upstream producers can be throttled with a valid/ready handshake. The read side has a mirror block, which is out of scope here.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits wide.
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH; legal range is 1..2**ADDR_W.
SYNC_STAGES, 2, flop stages on the incoming read pointer; minimum 2.

Ports:
clk  in  1  write-domain clock; the only clock of the block.
rst  in  1  asynchronous, active-high reset.
wr_valid  in  1  producer has data.
wr_ready  out  1  block can accept a word.
wr_en  out  1  RAM write strobe.
wr_addr  out  ADDR_W  RAM write address.
wr_ptr_gray  out  ADDR_W+1  registered Gray write pointer, exported to the read domain.
rd_ptr_gray  in  ADDR_W+1  Gray read pointer from the read domain; asynchronous to clk.
full  out  1  FIFO full; registered.
almost_full  out  1  level >= AF_THRESH; registered.
level  out  ADDR_W+1  write-side fill estimate, range 0..2**ADDR_W; registered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All flops clear on rst rising, with no clock required.
- Reset values: wr_ptr_gray=0, internal binary pointer=0, sync stages=0, full=0, almost_full=0, level=0.
- wr_ready = ~full & ~rst. It is held low while rst is asserted.
- accept = wr_valid & wr_ready.
- wr_en = accept, combinational. wr_addr = low ADDR_W bits of the current binary pointer, combinational from flops.
- On a clock edge with accept:
  - binary pointer += 1, wrapping modulo 2**(ADDR_W+1).
  - wr_ptr_gray <= gray(bin_next).
  - No accept means the pointers hold.
- Read pointer sync: rd_ptr_gray passes through SYNC_STAGES flops, giving rq_gray. No logic is permitted before the first stage. rq_bin = gray2bin(rq_gray), combinational.
- full <= (gray(bin_next) == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]}).
  - full asserts on the same edge that writes the last free slot, so no write is accepted when the FIFO is full.
- level <= bin_next - rq_bin, computed modulo 2**(ADDR_W+1). The result is never greater than 2**ADDR_W.
- almost_full <= ((bin_next - rq_bin) >= AF_THRESH).
- Latency:
  - A write updates full, level and almost_full on the same edge that advances the pointer.
  - A read-pointer change appears in full, level and almost_full SYNC_STAGES+1 edges later. Flags are therefore pessimistic: full deasserts late and never early.
- Simultaneous wr_valid and deassertion of full: wr_ready follows the registered full, so a write is accepted only in the cycle after full clears.
- Wrap-around: the pointer MSB toggles every 2**ADDR_W writes. full and level must stay correct across any number of wraps.
- Reset mid-operation:
  - All state returns to 0 immediately.
  - Any in-flight write is dropped, because wr_en is gated by wr_ready.
  - The read domain is reset by the system at the same time; no recovery handshake is required.

Decomposition:
- Shared include file (fifo_defs.vh) holds:
  - the gray2bin function and the existing bin2gray conversion,
  - the full-compare macro,
  - the default ADDR_W and SYNC_STAGES constants.
- Sub-module: the existing gray_ctr instance (WIDTH=ADDR_W+1, inc=accept).
  - gray_ctr has an active-low reset, so its rst_n is driven by ~rst.
  - Its gray output drives wr_ptr_gray; its gray_next drives the full compare.
  - The full-width binary pointer, including the MSB, is kept in this block for the level arithmetic.
- Sub-module: ptr_sync, an N-stage synchronizer with a WIDTH parameter.

Test Plan:
All scenarios use ADDR_W=4, AF_THRESH=12, SYNC_STAGES=2.
1. Assert rst mid-stream with no clock edge → all outputs are 0 immediately and wr_ready=0; deassert → wr_ready=1 on the next cycle.
2. rd_ptr_gray held at 0, wr_valid=1 for 20 cycles → exactly 16 wr_en pulses with wr_addr 0..15. full=1 after the 16th edge, level=16, almost_full=1 from level 12 onward, wr_ready=0.
3. From full, drive rd_ptr_gray=gray(1) → full drops and level=15 exactly 3 edges later, and one more write is then accepted to wr_addr 0.
4. Wrap: stream 100 words while rd_ptr_gray tracks wr_ptr_gray with a lag of 5 → level stays at 5 (±latency), full is never asserted, and wr_addr wraps 15→0 correctly, with the MSB toggling every 16 writes.
5. Almost-full boundary: write 11 words with reads stalled → almost_full=0. Write the 12th → almost_full=1 on that edge. Advance the read pointer by 1 → almost_full=0 three edges later.
6. wr_valid toggling randomly against full → no wr_en is ever asserted while full=1, and the written address sequence has no gaps and no duplicates.
